biquad8_coeff_loader: RTL and testbench
=======================================

Name: biquad8_coeff_loader

Overview:
- Upstream control stage for the 8-sample incremental biquad. It owns the coefficient write port of the DSP cascade.
- Holds a shadow bank of 18-bit coefficients that are written from a register-bus interface.
- On commit, streams the bank into the cascade in reverse order (highest index first), one coeff_wr_o pulse per word, then issues a single coeff_update_o pulse.
- The new coefficients therefore take effect in every DSP on the same clock.

Parameters:
- NCOEFF, 2, number of coefficient words per commit (high DSP word at index NCOEFF-1, low DSP word at index 0).
- ADR_BITS, 1, shadow address width; NCOEFF <= 2**ADR_BITS.
- WR_GAP, 0, idle cycles inserted between consecutive coeff_wr_o pulses (0 = back-to-back).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- reg_adr_i  in  ADR_BITS  shadow word address.
- reg_dat_i  in  18  shadow word data (signed coefficient, format set by the downstream filter).
- reg_wr_i  in  1  shadow write strobe, one word per cycle.
- commit_i  in  1  request to load the shadow bank into the cascade.
- coeff_dat_o  out  18  coefficient to the cascade B input.
- coeff_wr_o  out  1  cascade shift strobe (CEB1).
- coeff_update_o  out  1  cascade apply strobe (CEB2).
- busy_o  out  1  load sequence in progress.
- done_o  out  1  one-cycle pulse when the sequence completes.
- wr_err_o  out  1  sticky flag: shadow write attempted while busy; cleared by rst or by a commit_i that starts a sequence.

Behaviour:
- Reset (asynchronous, immediate):
  - all outputs 0; FSM returns to IDLE.
  - shadow bank cleared to 0; pending flag cleared.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Shadow writes:
  - When reg_wr_i=1 and busy_o=0: shadow[reg_adr_i] <= reg_dat_i.
  - Addresses >= NCOEFF are ignored silently.
  - When reg_wr_i=1 and busy_o=1: the write is dropped and wr_err_o is set.
- FSM states: IDLE, SHIFT, GAP, UPDATE, DONE.
  - IDLE: commit_i=1 (or pending=1) -> SHIFT with idx=NCOEFF-1; pending cleared; wr_err_o cleared.
  - SHIFT: drive coeff_dat_o=shadow[idx] and coeff_wr_o=1 for exactly one cycle.
    - If idx=0 -> UPDATE.
    - Otherwise idx decrements, then -> GAP if WR_GAP>0, else stay in SHIFT.
  - GAP: coeff_wr_o=0 for WR_GAP cycles, then -> SHIFT.
  - UPDATE: coeff_update_o=1 for one cycle, coeff_wr_o=0 -> DONE.
  - DONE: done_o=1 for one cycle -> IDLE, or directly -> SHIFT if pending=1.
- Outputs per state:
  - busy_o=1 in SHIFT, GAP, UPDATE, DONE; busy_o=0 in IDLE.
  - coeff_dat_o holds its last driven value outside SHIFT.
- Timing, WR_GAP=0, NCOEFF=2, commit_i sampled at cycle T:
  - coeff_wr_o high at T+1 (word 1) and T+2 (word 0).
  - coeff_update_o high at T+3.
  - done_o high at T+4; busy_o high T+1..T+4.
  - Total = NCOEFF + (NCOEFF-1)*WR_GAP + 2 cycles.
- Simultaneous and boundary events:
  - commit_i while busy sets pending, which is serviced straight after DONE. Multiple commits while busy collapse into one.
  - reg_wr_i and commit_i in the same IDLE cycle: the write lands first, and the sequence streams the new value.
  - coeff_wr_o and coeff_update_o are never high together.
  - coeff_update_o fires only after all NCOEFF shifts.
  - rst mid-sequence aborts the sequence. The cascade may hold partially shifted B1 values, but B2 (the active coefficients) is untouched because update was never issued.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (biquad_loader_st_t: IDLE, SHIFT, GAP, UPDATE, DONE);
  - the COEFF_BITS=18 constant;
  - coefficient index constants (COEFF_IDX_HIGH=1, COEFF_IDX_LOW=0).
- Shadow bank is a small register array inside the module; no sub-module is needed.
- The WR_GAP counter is inline.
- The top-level filter wrapper instantiates this block and wires coeff_dat_o, coeff_wr_o and coeff_update_o to the filter's coeff_dat_i, coeff_wr_i and coeff_update_i.

Test Plan:
- Basic load: write shadow[0]=18'h00123 and shadow[1]=18'h3FF00, commit_i at T.
  -> coeff_dat_o=3FF00 with wr at T+1; coeff_dat_o=00123 with wr at T+2; update at T+3; done at T+4; busy T+1..T+4.
- Gap: WR_GAP=2, same writes.
  -> wr pulses at T+1 and T+4; update at T+5; done at T+6; coeff_wr_o=0 at T+2..T+3.
- Busy write/commit: during the sequence, issue reg_wr_i (adr 0, data 18'h00055) and two commit_i pulses.
  -> wr_err_o=1; shadow[0] stays 00123; exactly one extra sequence follows DONE with no IDLE cycle between; wr_err_o clears at that restart.
- Same-cycle write+commit in IDLE: shadow[1]=18'h00ABC with commit_i.
  -> first streamed word is 00ABC.
- Reset mid-sequence: assert rst in the cycle after the first coeff_wr_o.
  -> all outputs 0 immediately; coeff_update_o is never asserted; shadow reads back 0; a later commit streams zeros.
- Out-of-range address (ADR_BITS=2, NCOEFF=2): write adr 3.
  -> ignored; wr_err_o stays 0; the streamed values are unchanged.

Source files
------------

// File: rtl/biquad8_coeff_loader_pkg.sv
// rtl/biquad8_coeff_loader_pkg.sv - shared types and constants for the biquad coefficient loader
package biquad8_coeff_loader_pkg;

    localparam int COEFF_BITS     = 18;
    localparam int COEFF_IDX_HIGH = 1;
    localparam int COEFF_IDX_LOW  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_UPDATE,
        ST_DONE
    } biquad_loader_st_t;

endpackage

// File: rtl/biquad8_coeff_loader.sv
// rtl/biquad8_coeff_loader.sv - shadow coefficient bank streamed into the DSP cascade on commit
module biquad8_coeff_loader
    import biquad8_coeff_loader_pkg::*;
#(
    parameter int NCOEFF   = 2,
    parameter int ADR_BITS = 1,
    parameter int WR_GAP   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADR_BITS-1:0]   reg_adr_i,
    input  logic [COEFF_BITS-1:0] reg_dat_i,
    input  logic                  reg_wr_i,
    input  logic                  commit_i,
    output logic [COEFF_BITS-1:0] coeff_dat_o,
    output logic                  coeff_wr_o,
    output logic                  coeff_update_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  wr_err_o
);

    localparam int NWORDS = 2 ** ADR_BITS;
    localparam int GAP_W  = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam logic [ADR_BITS-1:0] IDX_TOP  = ADR_BITS'(NCOEFF - 1);
    localparam logic [ADR_BITS-1:0] IDX_LOW  = ADR_BITS'(COEFF_IDX_LOW);
    localparam logic [GAP_W-1:0]    GAP_LOAD = GAP_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);

    biquad_loader_st_t     state_q;
    logic [ADR_BITS-1:0]   idx_q;
    logic [GAP_W-1:0]      gap_cnt_q;
    logic                  pending_q;
    logic [COEFF_BITS-1:0] coeff_dat_q;
    logic                  coeff_wr_q;
    logic                  coeff_update_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  wr_err_q;

    logic [COEFF_BITS-1:0] shadow_q [NWORDS];
    logic [COEFF_BITS-1:0] shadow_d [NWORDS];
    logic                  shadow_we;
    logic                  seq_start;

    assign shadow_we = reg_wr_i && !busy_q && (32'(reg_adr_i) < NCOEFF);

    // The first streamed word reads shadow_d so a write in the commit cycle is picked up.
    always_comb begin
        shadow_d = shadow_q;
        if (shadow_we) begin
            shadow_d[reg_adr_i] = reg_dat_i;
        end
    end

    assign seq_start = ((state_q == ST_IDLE) && (commit_i || pending_q)) ||
                       ((state_q == ST_DONE) && pending_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            gap_cnt_q      <= '0;
            pending_q      <= 1'b0;
            coeff_dat_q    <= '0;
            coeff_wr_q     <= 1'b0;
            coeff_update_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            wr_err_q       <= 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            shadow_q       <= shadow_d;
            coeff_wr_q     <= 1'b0;
            coeff_update_q <= 1'b0;
            done_q         <= 1'b0;

            if (reg_wr_i && busy_q) begin
                wr_err_q <= 1'b1;
            end else if (seq_start) begin
                wr_err_q <= 1'b0;
            end

            // A commit landing on the restart edge still counts for the following pass.
            if (seq_start) begin
                pending_q <= commit_i && busy_q;
            end else if (commit_i && busy_q) begin
                pending_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (seq_start) begin
                        state_q     <= ST_SHIFT;
                        idx_q       <= IDX_TOP;
                        coeff_wr_q  <= 1'b1;
                        coeff_dat_q <= shadow_d[IDX_TOP];
                        busy_q      <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (idx_q == IDX_LOW) begin
                        state_q        <= ST_UPDATE;
                        coeff_update_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                        if (WR_GAP > 0) begin
                            state_q   <= ST_GAP;
                            gap_cnt_q <= GAP_LOAD;
                        end else begin
                            coeff_wr_q  <= 1'b1;
                            coeff_dat_q <= shadow_q[idx_q - 1'b1];
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q     <= ST_SHIFT;
                        coeff_wr_q  <= 1'b1;
                        coeff_dat_q <= shadow_q[idx_q];
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                ST_UPDATE: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign coeff_dat_o    = coeff_dat_q;
    assign coeff_wr_o     = coeff_wr_q;
    assign coeff_update_o = coeff_update_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign wr_err_o       = wr_err_q;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// tb/tb_biquad8_coeff_loader.sv - directed self-checking bench for biquad8_coeff_loader
module tb_biquad8_coeff_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]  a_adr = '0;
    logic [17:0] a_dat = '0;
    logic        a_wr = 1'b0, a_commit = 1'b0;
    logic [17:0] a_cdat;
    logic        a_cwr, a_cupd, a_busy, a_done, a_err;

    logic [0:0]  b_adr = '0;
    logic [17:0] b_dat = '0;
    logic        b_wr = 1'b0, b_commit = 1'b0;
    logic [17:0] b_cdat;
    logic        b_cwr, b_cupd, b_busy, b_done, b_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    biquad8_coeff_loader #(.NCOEFF(2), .ADR_BITS(2), .WR_GAP(0)) dut (
        .clk(clk), .rst(rst),
        .reg_adr_i(a_adr), .reg_dat_i(a_dat), .reg_wr_i(a_wr), .commit_i(a_commit),
        .coeff_dat_o(a_cdat), .coeff_wr_o(a_cwr), .coeff_update_o(a_cupd),
        .busy_o(a_busy), .done_o(a_done), .wr_err_o(a_err)
    );

    biquad8_coeff_loader #(.NCOEFF(2), .ADR_BITS(1), .WR_GAP(2)) dut_gap (
        .clk(clk), .rst(rst),
        .reg_adr_i(b_adr), .reg_dat_i(b_dat), .reg_wr_i(b_wr), .commit_i(b_commit),
        .coeff_dat_o(b_cdat), .coeff_wr_o(b_cwr), .coeff_update_o(b_cupd),
        .busy_o(b_busy), .done_o(b_done), .wr_err_o(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [1:0] adr, input logic [17:0] dat);
        a_adr = adr; a_dat = dat; a_wr = 1'b1;
        tick();
        a_wr = 1'b0;
    endtask

    task automatic b_write(input logic [0:0] adr, input logic [17:0] dat);
        b_adr = adr; b_dat = dat; b_wr = 1'b1;
        tick();
        b_wr = 1'b0;
    endtask

    task automatic test_reset();
        logic [22:0] obs;
        repeat (2) tick();
        obs = {a_cwr, a_cupd, a_done, a_busy, a_err, a_cdat};
        checks++;
        if (obs !== 23'h0) begin errors++; $display("FAIL reset_a got %h exp %h", obs, 23'h0); end
        obs = {b_cwr, b_cupd, b_done, b_busy, b_err, b_cdat};
        checks++;
        if (obs !== 23'h0) begin errors++; $display("FAIL reset_b got %h exp %h", obs, 23'h0); end
        rst = 1'b0;
        repeat (2) tick();
        obs = {a_cwr, a_cupd, a_done, a_busy, a_err, a_cdat};
        checks++;
        if (obs !== 23'h0) begin errors++; $display("FAIL idle_after_reset got %h exp %h", obs, 23'h0); end
    endtask

    task automatic test_basic_load();
        logic [21:0] exp_v [5];
        logic [21:0] obs;
        exp_v[0] = {1'b1, 1'b0, 1'b0, 1'b1, 18'h3FF00};
        exp_v[1] = {1'b1, 1'b0, 1'b0, 1'b1, 18'h00123};
        exp_v[2] = {1'b0, 1'b1, 1'b0, 1'b1, 18'h00123};
        exp_v[3] = {1'b0, 1'b0, 1'b1, 1'b1, 18'h00123};
        exp_v[4] = {1'b0, 1'b0, 1'b0, 1'b0, 18'h00123};
        a_write(2'd0, 18'h00123);
        a_write(2'd1, 18'h3FF00);
        a_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        for (int k = 0; k < 5; k++) begin
            obs = {a_cwr, a_cupd, a_done, a_busy, a_cdat};
            checks++;
            if (obs !== exp_v[k]) begin
                errors++;
                $display("FAIL basic_load T+%0d got %h exp %h", k + 1, obs, exp_v[k]);
            end
            tick();
        end
    endtask

    task automatic test_gap();
        logic [21:0] exp_v [7];
        logic [21:0] obs;
        exp_v[0] = {1'b1, 1'b0, 1'b0, 1'b1, 18'h3FF00};
        exp_v[1] = {1'b0, 1'b0, 1'b0, 1'b1, 18'h3FF00};
        exp_v[2] = {1'b0, 1'b0, 1'b0, 1'b1, 18'h3FF00};
        exp_v[3] = {1'b1, 1'b0, 1'b0, 1'b1, 18'h00123};
        exp_v[4] = {1'b0, 1'b1, 1'b0, 1'b1, 18'h00123};
        exp_v[5] = {1'b0, 1'b0, 1'b1, 1'b1, 18'h00123};
        exp_v[6] = {1'b0, 1'b0, 1'b0, 1'b0, 18'h00123};
        b_write(1'b0, 18'h00123);
        b_write(1'b1, 18'h3FF00);
        b_commit = 1'b1;
        tick();
        b_commit = 1'b0;
        for (int k = 0; k < 7; k++) begin
            obs = {b_cwr, b_cupd, b_done, b_busy, b_cdat};
            checks++;
            if (obs !== exp_v[k]) begin
                errors++;
                $display("FAIL gap T+%0d got %h exp %h", k + 1, obs, exp_v[k]);
            end
            tick();
        end
    endtask

    task automatic test_busy_write_commit();
        logic [22:0] exp_v [9];
        logic [22:0] obs;
        exp_v[0] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 18'h3FF00};
        exp_v[1] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 18'h00123};
        exp_v[2] = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 18'h00123};
        exp_v[3] = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 18'h00123};
        exp_v[4] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 18'h3FF00};
        exp_v[5] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 18'h00123};
        exp_v[6] = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 18'h00123};
        exp_v[7] = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 18'h00123};
        exp_v[8] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00123};
        a_commit = 1'b1;
        tick();
        a_adr = 2'd0;
        a_dat = 18'h00055;
        for (int k = 0; k < 9; k++) begin
            obs = {a_cwr, a_cupd, a_done, a_busy, a_err, a_cdat};
            checks++;
            if (obs !== exp_v[k]) begin
                errors++;
                $display("FAIL busy_write_commit T+%0d got %h exp %h", k + 1, obs, exp_v[k]);
            end
            a_wr     = (k == 0);
            a_commit = (k == 0) || (k == 1);
            tick();
        end
        a_wr = 1'b0;
        a_commit = 1'b0;
    endtask

    task automatic test_same_cycle_write_commit();
        a_adr = 2'd1; a_dat = 18'h00ABC; a_wr = 1'b1; a_commit = 1'b1;
        tick();
        a_wr = 1'b0; a_commit = 1'b0;
        checks++;
        if ({a_cwr, a_cdat} !== {1'b1, 18'h00ABC}) begin
            errors++; $display("FAIL same_cycle_first got %h exp %h", {a_cwr, a_cdat}, {1'b1, 18'h00ABC});
        end
        tick();
        checks++;
        if ({a_cwr, a_cdat} !== {1'b1, 18'h00123}) begin
            errors++; $display("FAIL same_cycle_second got %h exp %h", {a_cwr, a_cdat}, {1'b1, 18'h00123});
        end
        repeat (3) tick();
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL same_cycle_idle got %b exp 0", a_busy); end
    endtask

    task automatic test_reset_mid_sequence();
        logic [22:0] obs;
        a_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        checks++;
        if ({a_cwr, a_cdat} !== {1'b1, 18'h00ABC}) begin
            errors++; $display("FAIL rst_mid_first_wr got %h exp %h", {a_cwr, a_cdat}, {1'b1, 18'h00ABC});
        end
        tick();
        #3 rst = 1'b1;
        #1;
        obs = {a_cwr, a_cupd, a_done, a_busy, a_err, a_cdat};
        checks++;
        if (obs !== 23'h0) begin errors++; $display("FAIL rst_mid_async got %h exp %h", obs, 23'h0); end
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({a_cupd, a_busy} !== 2'b00) begin
                errors++; $display("FAIL rst_mid_no_update c%0d got %b exp 00", k, {a_cupd, a_busy});
            end
        end
        a_write(2'd1, 18'h00777);
        a_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        checks++;
        if ({a_cwr, a_cdat} !== {1'b1, 18'h00777}) begin
            errors++; $display("FAIL rst_mid_word1 got %h exp %h", {a_cwr, a_cdat}, {1'b1, 18'h00777});
        end
        tick();
        checks++;
        if ({a_cwr, a_cdat} !== {1'b1, 18'h00000}) begin
            errors++; $display("FAIL rst_mid_word0_cleared got %h exp %h", {a_cwr, a_cdat}, {1'b1, 18'h00000});
        end
        tick();
        checks++;
        if ({a_cwr, a_cupd} !== 2'b01) begin
            errors++; $display("FAIL rst_mid_update got %b exp 01", {a_cwr, a_cupd});
        end
        repeat (2) tick();
    endtask

    task automatic test_out_of_range();
        a_write(2'd3, 18'h3FFFF);
        a_write(2'd2, 18'h2AAAA);
        checks++;
        if (a_err !== 1'b0) begin errors++; $display("FAIL oor_no_err got %b exp 0", a_err); end
        a_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        checks++;
        if ({a_cwr, a_cdat} !== {1'b1, 18'h00777}) begin
            errors++; $display("FAIL oor_word1 got %h exp %h", {a_cwr, a_cdat}, {1'b1, 18'h00777});
        end
        tick();
        checks++;
        if ({a_cwr, a_cdat} !== {1'b1, 18'h00000}) begin
            errors++; $display("FAIL oor_word0 got %h exp %h", {a_cwr, a_cdat}, {1'b1, 18'h00000});
        end
        repeat (3) tick();
        checks++;
        if ({a_busy, a_err} !== 2'b00) begin
            errors++; $display("FAIL oor_end got %b exp 00", {a_busy, a_err});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_load();
        test_gap();
        test_busy_write_commit();
        test_same_cycle_write_commit();
        test_reset_mid_sequence();
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
